cp0: RTL and testbench
======================

CP0 -- requirements
Module: cp0

Interface
REQ-001 SHALL have parameter PRID, default 32'h20160001, value returned for PRId register (read-only).
REQ-002 SHALL have Clk  input  1  clock; all state updates on posedge Clk.
REQ-003 SHALL have Rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have A1  input  5  read register number (mfc0).
REQ-005 SHALL have A2  input  5  write register number (mtc0).
REQ-006 SHALL have DIn  input  32  write data.
REQ-007 SHALL have We  input  1  write enable for A2.
REQ-008 SHALL have PC  input  32  address of the instruction being interrupted or excepted (word aligned).
REQ-009 SHALL have BD  input  1  instruction at PC is in a branch delay slot.
REQ-010 SHALL have ExcCode  input  5  synchronous exception code; 0 = no exception.
REQ-011 SHALL have HWInt  input  6  level-sensitive device interrupt lines; bit 0 = timer0 IRQ, bit 1 = timer1 IRQ.
REQ-012 SHALL have EXLClr  input  1  eret executing; clears SR.EXL.
REQ-013 SHALL have IntReq  output  1  take exception/interrupt this cycle; flush and redirect to handler.
REQ-014 SHALL have EPC  output  32  current EPC register value.
REQ-015 SHALL have DOut  output  32  value of register A1.

Function
REQ-016 SHALL implement SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
REQ-017 SHALL implement Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0; Cause is not writable by We.
REQ-018 SHALL implement EPC (14), bits [1:0] always 0; PRId (15) = PRID.
REQ-019 SHALL drive DOut combinationally from A1 with pre-edge register values; unmapped A1 reads 0.
REQ-020 SHALL load Cause.IP <= HWInt every cycle, regardless of any other event.
REQ-021 SHALL compute HwReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL, combinationally from live HWInt.
REQ-022 SHALL compute ExcReq = (ExcCode != 0) & !SR.EXL.
REQ-023 SHALL drive IntReq = HwReq | ExcReq, combinationally, zero latency.
REQ-024 SHALL give HwReq priority over ExcReq: Cause.ExcCode <= 0 when HwReq, else ExcCode.
REQ-025 SHALL on IntReq edge: SR.EXL <= 1; Cause.BD <= BD; EPC <= BD ? PC-4 : PC (32-bit wrap, low 2 bits forced 0).
REQ-026 SHALL ignore We on a cycle where IntReq is 1 (exception entry wins over mtc0).
REQ-027 SHALL on We (no IntReq): A2=12 loads IM, EXL, IE from DIn; A2=14 loads EPC <= {DIn[31:2],2'b00}; other A2 ignored.
REQ-028 SHALL on EXLClr (no IntReq) clear SR.EXL; EXLClr and We to SR on the same edge: EXLClr wins for EXL, IM/IE take DIn.
REQ-029 SHALL mask all new requests while SR.EXL=1 (no nesting); pending HWInt then raises IntReq on the first cycle after EXL clears.
REQ-030 SHALL treat HWInt purely as levels; no latching, so a line dropped before being enabled leaves no trace.

Reset
REQ-031 SHALL on Rst clear SR, Cause and EPC to 0; IntReq then 0, DOut per A1 (PRId still PRID).
REQ-032 SHALL give Rst priority over IntReq, We and EXLClr on the same edge.

Structure
REQ-033 SHALL place register numbers (12-15), SR/Cause bit positions and ExcCode values (Int=0, AdEL=4, AdES=5, RI=10, Ov=12) in the shared CPU package.
REQ-034 SHALL be a single module; no sub-module.

Verification
REQ-035 Write SR=32'h0000_0401, HWInt=6'b000001, PC=32'h0000_3010 -> IntReq=1 same cycle; next edge EXL=1, EPC=32'h3010, Cause=32'h0000_0400.
REQ-036 ExcCode=10, BD=1, PC=32'h0000_3008, SR=0 -> IntReq=1; next edge EPC=32'h3004, Cause=32'h8000_0028, SR.EXL=1.
REQ-037 EXL=1, HWInt=6'b000001 held, SR.IM/IE enabled -> IntReq=0; assert EXLClr one cycle -> IntReq=1 on the following cycle.
REQ-038 HwReq and ExcCode=12 same cycle -> Cause.ExcCode=0; same cycle We to EPC with 32'hFFFF_FFFF -> EPC=PC, not DIn.
REQ-039 Write EPC with 32'h0000_3013 -> A1=14 reads 32'h0000_3010; A1=15 reads 32'h2016_0001; A1=3 reads 0.
REQ-040 Rst asserted while EXL=1 and HWInt active -> SR=Cause=EPC=0 after the edge; IntReq=0 because IE=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CPU definitions for coprocessor 0: register numbers, SR/Cause field
// positions and exception codes.
package cp0_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned HWINT_W = 6;
  localparam int unsigned EXC_W   = 5;

  localparam logic [REG_W-1:0] REG_SR    = 5'd12;
  localparam logic [REG_W-1:0] REG_CAUSE = 5'd13;
  localparam logic [REG_W-1:0] REG_EPC   = 5'd14;
  localparam logic [REG_W-1:0] REG_PRID  = 5'd15;

  localparam int unsigned SR_IE        = 0;
  localparam int unsigned SR_EXL       = 1;
  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned SR_IM_HI     = 15;
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_BD     = 31;

  typedef enum logic [EXC_W-1:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0_if.sv
// Pipeline-to-CP0 connection: mfc0/mtc0 access, exception inputs and redirect outputs.
interface cp0_if;
  import cp0_pkg::*;

  logic [REG_W-1:0]   A1;
  logic [REG_W-1:0]   A2;
  logic [DATA_W-1:0]  DIn;
  logic               We;
  logic [DATA_W-1:0]  PC;
  logic               BD;
  logic [EXC_W-1:0]   ExcCode;
  logic [HWINT_W-1:0] HWInt;
  logic               EXLClr;
  logic               IntReq;
  logic [DATA_W-1:0]  EPC;
  logic [DATA_W-1:0]  DOut;

  modport master (output A1, A2, DIn, We, PC, BD, ExcCode, HWInt, EXLClr,
                  input  IntReq, EPC, DOut);
  modport slave  (input  A1, A2, DIn, We, PC, BD, ExcCode, HWInt, EXLClr,
                  output IntReq, EPC, DOut);
endinterface

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId registers, interrupt and exception entry.
// IntReq and DOut are combinational so the pipeline can flush in the same cycle.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h2016_0001
) (
  input  logic  Clk,
  input  logic  Rst,
  cp0_if.slave  bus
);

  logic [HWINT_W-1:0] r_im;
  logic               r_exl;
  logic               r_ie;
  logic               r_bd;
  logic [HWINT_W-1:0] r_ip;
  logic [EXC_W-1:0]   r_exccode;
  logic [DATA_W-3:0]  r_epc;

  logic               w_hw_req;
  logic               w_exc_req;
  logic               w_int_req;
  logic [DATA_W-1:0]  w_epc_next;
  logic [DATA_W-1:0]  w_sr;
  logic [DATA_W-1:0]  w_cause;
  logic [DATA_W-1:0]  w_epc;

  // Requests are masked while EXL is set, so handlers never nest.
  assign w_hw_req   = (|(bus.HWInt & r_im)) & r_ie & ~r_exl;
  assign w_exc_req  = (bus.ExcCode != EXC_W'(0)) & ~r_exl;
  assign w_int_req  = w_hw_req | w_exc_req;
  assign w_epc_next = bus.BD ? (bus.PC - 32'd4) : bus.PC;

  always_comb begin
    w_sr    = '0;
    w_cause = '0;
    w_sr[SR_IM_HI:SR_IM_LO]          = r_im;
    w_sr[SR_EXL]                     = r_exl;
    w_sr[SR_IE]                      = r_ie;
    w_cause[CAUSE_BD]                = r_bd;
    w_cause[CAUSE_IP_HI:CAUSE_IP_LO] = r_ip;
    w_cause[CAUSE_EXC_HI:CAUSE_EXC_LO] = r_exccode;
  end

  assign w_epc = {r_epc, 2'b00};

  always_comb begin
    unique case (bus.A1)
      REG_SR:    bus.DOut = w_sr;
      REG_CAUSE: bus.DOut = w_cause;
      REG_EPC:   bus.DOut = w_epc;
      REG_PRID:  bus.DOut = PRID;
      default:   bus.DOut = '0;
    endcase
  end

  assign bus.IntReq = w_int_req;
  assign bus.EPC    = w_epc;

  // Exception entry beats mtc0; EXLClr beats an SR write for the EXL bit only.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= bus.HWInt;
      if (w_int_req) begin
        r_exl     <= 1'b1;
        r_bd      <= bus.BD;
        r_epc     <= w_epc_next[DATA_W-1:2];
        r_exccode <= w_hw_req ? EXC_W'(EXC_INT) : bus.ExcCode;
      end else begin
        if (bus.We && (bus.A2 == REG_SR)) begin
          r_im  <= bus.DIn[SR_IM_HI:SR_IM_LO];
          r_exl <= bus.DIn[SR_EXL];
          r_ie  <= bus.DIn[SR_IE];
        end
        if (bus.We && (bus.A2 == REG_EPC)) begin
          r_epc <= bus.DIn[DATA_W-1:2];
        end
        if (bus.EXLClr) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: vector table plus hand-built eret and reset sequences.
module tb_cp0;
  import cp0_pkg::*;

  localparam logic [31:0] PRID_VAL = 32'h2016_0001;

  typedef struct {
    string       name;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        exlclr;
    logic        exp_int;   // IntReq before the edge
    logic [31:0] exp_dout;  // DOut before the edge
    logic [31:0] exp_epc;   // EPC after the edge
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t sb[$];
  vec_t tbl[16];

  cp0_if bus_if();

  cp0 #(.PRID(PRID_VAL)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic [4:0] a1, logic [4:0] a2, logic [31:0] din,
                              logic we, logic [31:0] pc, logic bd, logic [4:0] exc,
                              logic [5:0] hw, logic exlclr, logic ei, logic [31:0] ed,
                              logic [31:0] ee);
    vec_t v;
    v.name = n; v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.pc = pc; v.bd = bd;
    v.exc = exc; v.hw = hw; v.exlclr = exlclr;
    v.exp_int = ei; v.exp_dout = ed; v.exp_epc = ee;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus_if.A1 = '0; bus_if.A2 = '0; bus_if.DIn = '0; bus_if.We = 1'b0;
    bus_if.PC = '0; bus_if.BD = 1'b0; bus_if.ExcCode = '0; bus_if.HWInt = '0;
    bus_if.EXLClr = 1'b0;
  endtask

  // One cycle: drive at negedge, check combinational outputs, then EPC after the edge.
  task automatic step(vec_t v);
    vec_t e;
    @(negedge clk);
    bus_if.A1 = v.a1; bus_if.A2 = v.a2; bus_if.DIn = v.din; bus_if.We = v.we;
    bus_if.PC = v.pc; bus_if.BD = v.bd; bus_if.ExcCode = v.exc; bus_if.HWInt = v.hw;
    bus_if.EXLClr = v.exlclr;
    sb.push_back(v);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check({e.name, "_intreq"}, 32'(bus_if.IntReq), 32'(e.exp_int));
      check({e.name, "_dout"}, bus_if.DOut, e.exp_dout);
      @(posedge clk);
      #1;
      check({e.name, "_epc"}, bus_if.EPC, e.exp_epc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rst_exp [4];
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_intreq", 32'(bus_if.IntReq), 32'd0);
    check("rst_epc", bus_if.EPC, 32'd0);
    rst_exp[0] = 32'd0; rst_exp[1] = 32'd0; rst_exp[2] = 32'd0; rst_exp[3] = PRID_VAL;
    for (int i = 0; i < 4; i++) begin
      bus_if.A1 = 5'(12 + i);
      #1;
      check($sformatf("rst_read_%0d", 12 + i), bus_if.DOut, rst_exp[i]);
    end

    //        name               a1  a2  din            we  pc            bd  exc hw      clr int dout           epc
    tbl[0]  = mk("sr_write",      12, 12, 32'h0000_0401, 1, 32'h0,        0, 0,  6'd0, 0, 0, 32'h0,         32'h0);
    tbl[1]  = mk("hw_int_take",   12, 0,  32'h0,         0, 32'h0000_3010, 0, 0,  6'd1, 0, 1, 32'h0000_0401, 32'h3010);
    tbl[2]  = mk("sr_exl_set",    12, 0,  32'h0,         0, 32'h0000_3020, 0, 0,  6'd1, 0, 0, 32'h0000_0403, 32'h3010);
    tbl[3]  = mk("cause_hw",      13, 0,  32'h0,         0, 32'h0,        0, 0,  6'd0, 0, 0, 32'h0000_0400, 32'h3010);
    tbl[4]  = mk("eret",          12, 0,  32'h0,         0, 32'h0,        0, 0,  6'd0, 1, 0, 32'h0000_0403, 32'h3010);
    tbl[5]  = mk("sr_clear",      12, 12, 32'h0,         1, 32'h0,        0, 0,  6'd0, 0, 0, 32'h0000_0401, 32'h3010);
    tbl[6]  = mk("exc_ri_bd",     12, 0,  32'h0,         0, 32'h0000_3008, 1, 10, 6'd0, 0, 1, 32'h0,         32'h3004);
    tbl[7]  = mk("cause_exc",     13, 0,  32'h0,         0, 32'h0,        0, 0,  6'd0, 0, 0, 32'h8000_0028, 32'h3004);
    tbl[8]  = mk("exc_masked",    12, 0,  32'h0,         0, 32'h0000_4000, 0, 4,  6'd0, 0, 0, 32'h0000_0002, 32'h3004);
    tbl[9]  = mk("epc_write",     14, 14, 32'h0000_3013, 1, 32'h0,        0, 0,  6'd0, 0, 0, 32'h0000_3004, 32'h3010);
    tbl[10] = mk("epc_read",      14, 0,  32'h0,         0, 32'h0,        0, 0,  6'd0, 0, 0, 32'h0000_3010, 32'h3010);
    tbl[11] = mk("prid_read",     15, 0,  32'h0,         0, 32'h0,        0, 0,  6'd0, 0, 0, PRID_VAL,      32'h3010);
    tbl[12] = mk("unmapped_read", 3,  0,  32'h0,         0, 32'h0,        0, 0,  6'd0, 0, 0, 32'h0,         32'h3010);
    tbl[13] = mk("sr_wr_exlclr",  12, 12, 32'h0000_0403, 1, 32'h0,        0, 0,  6'd0, 1, 0, 32'h0000_0002, 32'h3010);
    tbl[14] = mk("hw_over_exc",   12, 14, 32'hFFFF_FFFF, 1, 32'h0000_3100, 0, 12, 6'd1, 0, 1, 32'h0000_0401, 32'h3100);
    tbl[15] = mk("cause_prio",    13, 0,  32'h0,         0, 32'h0,        0, 0,  6'd0, 0, 0, 32'h0000_0400, 32'h3100);

    for (int i = 0; i < 16; i++) step(tbl[i]);

    // Pending line held across EXL: no request until the cycle after eret.
    step(mk("exl_hold",       12, 0, 32'h0, 0, 32'h0,        0, 0, 6'd1, 0, 0, 32'h0000_0403, 32'h3100));
    step(mk("exl_clr_cycle",  12, 0, 32'h0, 0, 32'h0,        0, 0, 6'd1, 1, 0, 32'h0000_0403, 32'h3100));
    step(mk("pending_fires",  12, 0, 32'h0, 0, 32'h0000_3200, 0, 0, 6'd1, 0, 1, 32'h0000_0401, 32'h3200));

    // Reset while EXL=1 with the line still asserted.
    rst = 1'b1;
    step(mk("rst_in_exl",     12, 0, 32'h0, 0, 32'h0000_3300, 0, 0, 6'd1, 0, 0, 32'h0000_0403, 32'h0));
    rst = 1'b0;
    step(mk("post_rst_cause", 13, 0, 32'h0, 0, 32'h0,        0, 0, 6'd1, 0, 0, 32'h0,         32'h0));
    step(mk("post_rst_sr",    12, 0, 32'h0, 0, 32'h0,        0, 0, 6'd1, 0, 0, 32'h0,         32'h0));

    if (sb.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
